rx_axis_arbiter: RTL and testbench

RX_AXIS_ARBITER -- requirements
Module: rx_axis_arbiter

---
 rtl/rx_axis_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rx_axis_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_axis_arbiter.sv
// rx_axis_arbiter: merges two rx MAC AXI-Stream sources into one output stream.
// Whole frames are arbitrated (no beat interleaving) with round-robin tie-break,
// frames longer than MAX_FRAME_LEN are truncated and their tail is dropped.
//
// Handshake: a beat moves on any port only in a cycle where tvalid and trdy are
// both high at the rising edge. A source holds tvalid/tdata/tlast/tuser stable
// until accepted. trdy never depends on the same port's tvalid.
module rx_axis_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] s0_rx_axis_tdata,
    input  logic                  s0_rx_axis_tvalid,
    input  logic                  s0_rx_axis_tlast,
    input  logic                  s0_rx_axis_tuser,
    output logic                  s0_rx_axis_trdy,

    input  logic [DATA_WIDTH-1:0] s1_rx_axis_tdata,
    input  logic                  s1_rx_axis_tvalid,
    input  logic                  s1_rx_axis_tlast,
    input  logic                  s1_rx_axis_tuser,
    output logic                  s1_rx_axis_trdy,

    output logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
    output logic                  m_rx_axis_tvalid,
    output logic                  m_rx_axis_tlast,
    output logic                  m_rx_axis_tuser,
    input  logic                  m_rx_axis_trdy,

    output logic [1:0]            grant,
    output logic                  trunc_pulse,
    output logic [1:0]            fsm_state
);

    localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
    // Count value held while the MAX_FRAME_LEN-th beat is being accepted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_FRAME_LEN - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;

    logic [1:0]            state;
    logic                  last_grant;   // index of the source granted most recently
    logic [CNT_W-1:0]      beat_cnt;

    logic                  sel_src;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic                  sel_user;
    logic                  sel_trdy;
    logic                  accept;
    logic                  fwd;
    logic                  at_limit;
    logic                  truncate;
    logic                  any_valid;
    logic                  pick;

    assign fsm_state = state;

    // Mux the granted source and derive the per-cycle handshake decisions.
    always_comb begin
        sel_src   = grant[1];
        sel_valid = sel_src ? s1_rx_axis_tvalid : s0_rx_axis_tvalid;
        sel_data  = sel_src ? s1_rx_axis_tdata  : s0_rx_axis_tdata;
        sel_last  = sel_src ? s1_rx_axis_tlast  : s0_rx_axis_tlast;
        sel_user  = sel_src ? s1_rx_axis_tuser  : s0_rx_axis_tuser;

        // ACTIVE: accept only when the output register is empty or draining.
        // DROP: swallow beats unconditionally. IDLE: accept nothing.
        sel_trdy = 1'b0;
        if (state == ST_ACTIVE) begin
            sel_trdy = ~m_rx_axis_tvalid | m_rx_axis_trdy;
        end else if (state == ST_DROP) begin
            sel_trdy = 1'b1;
        end

        s0_rx_axis_trdy = grant[0] & sel_trdy;
        s1_rx_axis_trdy = grant[1] & sel_trdy;

        accept   = (s0_rx_axis_trdy & s0_rx_axis_tvalid) |
                   (s1_rx_axis_trdy & s1_rx_axis_tvalid);
        fwd      = accept & (state == ST_ACTIVE);
        at_limit = (beat_cnt == LAST_CNT);
        truncate = fwd & at_limit & ~sel_last;

        // Tie goes to the source that did not win last time.
        any_valid = s0_rx_axis_tvalid | s1_rx_axis_tvalid;
        if (s0_rx_axis_tvalid & s1_rx_axis_tvalid) begin
            pick = ~last_grant;
        end else begin
            pick = s1_rx_axis_tvalid;
        end
    end

    // Frame-level FSM: ownership is decided only in IDLE and held to frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        state      <= ST_ACTIVE;
                        grant      <= pick ? 2'b10 : 2'b01;
                        last_grant <= pick;
                        beat_cnt   <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (fwd) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (sel_last) begin
                            state <= ST_IDLE;
                            grant <= 2'b00;
                        end else if (at_limit) begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept && sel_last) begin
                        state <= ST_IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Single output register stage; a truncated beat is closed as an errored last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_rx_axis_tvalid <= 1'b0;
            m_rx_axis_tdata  <= '0;
            m_rx_axis_tlast  <= 1'b0;
            m_rx_axis_tuser  <= 1'b0;
            trunc_pulse      <= 1'b0;
        end else begin
            trunc_pulse <= truncate;
            if (fwd) begin
                m_rx_axis_tvalid <= 1'b1;
                m_rx_axis_tdata  <= sel_data;
                m_rx_axis_tlast  <= sel_last | at_limit;
                m_rx_axis_tuser  <= sel_user | (at_limit & ~sel_last);
            end else if (m_rx_axis_trdy) begin
                m_rx_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_axis_arbiter.sv
// Testbench for rx_axis_arbiter: cycle vector table plus multi-cycle frame sequences.
module tb_rx_axis_arbiter;

    localparam int DW    = 8;
    localparam int MAXF  = 12;
    localparam int BOUND = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic          s0_tvalid, s0_tlast, s0_tuser, s0_trdy;
    logic          s1_tvalid, s1_tlast, s1_tuser, s1_trdy;
    logic          m_tvalid, m_tlast, m_tuser, m_trdy;
    logic [1:0]    grant;
    logic          trunc_pulse;
    logic [1:0]    fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int trunc_cnt = 0;
    int rdy_mode = 0;
    logic chk_en = 1'b0;
    logic stalled = 1'b0;
    logic [DW+1:0] held;

    logic [DW+1:0] exp_q[$];

    rx_axis_arbiter #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(MAXF)) dut (
        .clk(clk), .reset(reset),
        .s0_rx_axis_tdata(s0_tdata), .s0_rx_axis_tvalid(s0_tvalid),
        .s0_rx_axis_tlast(s0_tlast), .s0_rx_axis_tuser(s0_tuser),
        .s0_rx_axis_trdy(s0_trdy),
        .s1_rx_axis_tdata(s1_tdata), .s1_rx_axis_tvalid(s1_tvalid),
        .s1_rx_axis_tlast(s1_tlast), .s1_rx_axis_tuser(s1_tuser),
        .s1_rx_axis_trdy(s1_trdy),
        .m_rx_axis_tdata(m_tdata), .m_rx_axis_tvalid(m_tvalid),
        .m_rx_axis_tlast(m_tlast), .m_rx_axis_tuser(m_tuser),
        .m_rx_axis_trdy(m_trdy),
        .grant(grant), .trunc_pulse(trunc_pulse), .fsm_state(fsm_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic rst; logic mrdy;
        logic v0; logic [DW-1:0] d0; logic l0; logic u0;
        logic v1; logic [DW-1:0] d1; logic l1; logic u1;
        logic t0; logic t1; logic mv; logic [DW-1:0] md; logic ml; logic mu;
        logic [1:0] g; logic tp;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(
        input logic rst, input logic mrdy,
        input logic v0, input logic [DW-1:0] d0, input logic l0, input logic u0,
        input logic v1, input logic [DW-1:0] d1, input logic l1, input logic u1,
        input logic t0, input logic t1, input logic mv, input logic [DW-1:0] md,
        input logic ml, input logic mu, input logic [1:0] g, input logic tp);
        vec_t r;
        r.rst = rst; r.mrdy = mrdy;
        r.v0 = v0; r.d0 = d0; r.l0 = l0; r.u0 = u0;
        r.v1 = v1; r.d1 = d1; r.l1 = l1; r.u1 = u1;
        r.t0 = t0; r.t1 = t1; r.mv = mv; r.md = md; r.ml = ml; r.mu = mu;
        r.g = g; r.tp = tp;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input int src, input logic v, input logic [DW-1:0] d,
                         input logic l, input logic u);
        if (src == 0) begin
            s0_tvalid = v; s0_tdata = d; s0_tlast = l; s0_tuser = u;
        end else begin
            s1_tvalid = v; s1_tdata = d; s1_tlast = l; s1_tuser = u;
        end
    endtask

    task automatic send_frame(input int src, input int n, input logic [DW-1:0] base,
                              input logic user_last);
        for (int k = 0; k < n; k++) begin
            int t;
            logic acc;
            drive(src, 1'b1, DW'(base + k), (k == n - 1), user_last & (k == n - 1));
            t = 0;
            acc = 1'b0;
            while (!acc && t < BOUND) begin
                @(negedge clk);
                acc = (src == 0) ? s0_trdy : s1_trdy;
                @(posedge clk);
                #1;
                t++;
            end
            check($sformatf("src%0d_beat%0d_accepted", src, k), {31'd0, acc}, 32'd1);
            if (!acc) begin
                drive(src, 1'b0, '0, 1'b0, 1'b0);
                return;
            end
        end
        drive(src, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic push_frame(input int n, input logic [DW-1:0] base, input logic user_last,
                              input logic truncated);
        for (int k = 0; k < n; k++) begin
            logic l, u;
            l = (k == n - 1);
            u = (k == n - 1) & (user_last | truncated);
            exp_q.push_back({u, l, DW'(base + k)});
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && grant == 2'b00 && !m_tvalid) && t < BOUND) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_grant_idle"}, {30'd0, grant}, 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_m_tvalid"}, {31'd0, m_tvalid}, 32'd0);
        check({name, "_m_tdata"}, {24'd0, m_tdata}, 32'd0);
        check({name, "_m_tlast"}, {31'd0, m_tlast}, 32'd0);
        check({name, "_m_tuser"}, {31'd0, m_tuser}, 32'd0);
        check({name, "_grant"}, {30'd0, grant}, 32'd0);
        check({name, "_trunc"}, {31'd0, trunc_pulse}, 32'd0);
        check({name, "_trdy"}, {30'd0, s1_trdy, s0_trdy}, 32'd0);
        check({name, "_state_idle"}, {30'd0, fsm_state}, 32'd0);
    endtask

    // Downstream ready pattern: mode 1 toggles every cycle
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) m_trdy = ~m_trdy;
    end

    // Scoreboard: every output transfer pops exp_q; stalled beats must hold
    always @(negedge clk) begin
        if (trunc_pulse) trunc_cnt++;
        if (chk_en) begin
            if (stalled) begin
                check("stall_hold", {21'd0, m_tvalid, m_tuser, m_tlast, m_tdata},
                      {21'd0, 1'b1, held});
            end
            if (m_tvalid && m_trdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {22'd0, m_tuser, m_tlast, m_tdata}, 32'hFFFF_FFFF);
                end else begin
                    logic [DW+1:0] e;
                    e = exp_q.pop_front();
                    check("out_beat", {22'd0, m_tuser, m_tlast, m_tdata}, {22'd0, e});
                end
            end
            stalled = m_tvalid & ~m_trdy;
            held = {m_tuser, m_tlast, m_tdata};
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        int tc;
        int acc_n;
        logic a;

        // Vector table: inputs held for one cycle, expected outputs mid-cycle.
        //            rst m  v0 d0     l0 u0 v1 d1     l1 u1 | t0 t1 mv md     ml mu g      tp
        vecs[0]  = mk(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        vecs[1]  = mk(0, 1, 1, 8'hA1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        vecs[2]  = mk(0, 1, 1, 8'hA1, 0, 0, 0, 8'h00, 0, 0,   1, 0, 0, 8'h00, 0, 0, 2'b01, 0);
        vecs[3]  = mk(0, 1, 1, 8'hA2, 0, 0, 0, 8'h00, 0, 0,   1, 0, 1, 8'hA1, 0, 0, 2'b01, 0);
        vecs[4]  = mk(0, 1, 1, 8'hA3, 1, 0, 0, 8'h00, 0, 0,   1, 0, 1, 8'hA2, 0, 0, 2'b01, 0);
        vecs[5]  = mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 1, 8'hA3, 1, 0, 2'b00, 0);
        vecs[6]  = mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        vecs[7]  = mk(0, 1, 1, 8'hB0, 1, 0, 1, 8'hC0, 1, 1,   0, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        vecs[8]  = mk(0, 1, 1, 8'hB0, 1, 0, 1, 8'hC0, 1, 1,   0, 1, 0, 8'h00, 0, 0, 2'b10, 0);
        vecs[9]  = mk(0, 1, 1, 8'hB0, 1, 0, 0, 8'h00, 0, 0,   0, 0, 1, 8'hC0, 1, 1, 2'b00, 0);
        vecs[10] = mk(0, 1, 1, 8'hB0, 1, 0, 0, 8'h00, 0, 0,   1, 0, 0, 8'h00, 0, 0, 2'b01, 0);
        vecs[11] = mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 1, 8'hB0, 1, 0, 2'b00, 0);
        vecs[12] = mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        vecs[13] = mk(0, 0, 1, 8'hD0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        vecs[14] = mk(0, 0, 1, 8'hD0, 0, 0, 0, 8'h00, 0, 0,   1, 0, 0, 8'h00, 0, 0, 2'b01, 0);
        vecs[15] = mk(0, 0, 1, 8'hD1, 1, 0, 0, 8'h00, 0, 0,   0, 0, 1, 8'hD0, 0, 0, 2'b01, 0);
        vecs[16] = mk(0, 0, 1, 8'hD1, 1, 0, 0, 8'h00, 0, 0,   0, 0, 1, 8'hD0, 0, 0, 2'b01, 0);
        vecs[17] = mk(0, 1, 1, 8'hD1, 1, 0, 0, 8'h00, 0, 0,   1, 0, 1, 8'hD0, 0, 0, 2'b01, 0);
        vecs[18] = mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 1, 8'hD1, 1, 0, 2'b00, 0);
        vecs[19] = mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 0, 0, 2'b00, 0);

        // Clock/reset
        reset = 1'b1;
        m_trdy = 1'b1;
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            reset  = vecs[i].rst;
            m_trdy = vecs[i].mrdy;
            drive(0, vecs[i].v0, vecs[i].d0, vecs[i].l0, vecs[i].u0);
            drive(1, vecs[i].v1, vecs[i].d1, vecs[i].l1, vecs[i].u1);
            @(negedge clk);
            check($sformatf("v%0d_s0_trdy", i), {31'd0, s0_trdy}, {31'd0, vecs[i].t0});
            check($sformatf("v%0d_s1_trdy", i), {31'd0, s1_trdy}, {31'd0, vecs[i].t1});
            check($sformatf("v%0d_m_tvalid", i), {31'd0, m_tvalid}, {31'd0, vecs[i].mv});
            check($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vecs[i].g});
            check($sformatf("v%0d_trunc", i), {31'd0, trunc_pulse}, {31'd0, vecs[i].tp});
            if (vecs[i].mv) begin
                check($sformatf("v%0d_m_beat", i), {22'd0, m_tuser, m_tlast, m_tdata},
                      {22'd0, vecs[i].mu, vecs[i].ml, vecs[i].md});
            end
            @(posedge clk);
            #1;
        end

        // Reset state, then both sources competing with 4-beat frames
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        push_frame(4, 8'h10, 1'b0, 1'b0);
        push_frame(4, 8'h90, 1'b0, 1'b0);
        push_frame(4, 8'h20, 1'b0, 1'b0);
        push_frame(4, 8'hA0, 1'b0, 1'b0);
        fork
            begin
                send_frame(0, 4, 8'h10, 1'b0);
                send_frame(0, 4, 8'h20, 1'b0);
            end
            begin
                send_frame(1, 4, 8'h90, 1'b0);
                send_frame(1, 4, 8'hA0, 1'b0);
            end
        join
        wait_done("alternate");

        // Toggling back-pressure through a 10-beat frame
        rdy_mode = 1;
        push_frame(10, 8'h30, 1'b0, 1'b0);
        send_frame(0, 10, 8'h30, 1'b0);
        wait_done("toggle");
        rdy_mode = 0;
        m_trdy = 1'b1;

        // Oversize frame from source 1: truncated at MAXF, tail dropped
        trunc_cnt = 0;
        push_frame(MAXF, 8'h40, 1'b0, 1'b1);
        send_frame(1, MAXF + 4, 8'h40, 1'b0);
        wait_done("truncate");
        check("trunc_count", trunc_cnt, 1);

        // Exactly MAXF beats ending with tlast: passes untouched
        push_frame(MAXF, 8'h50, 1'b0, 1'b0);
        send_frame(0, MAXF, 8'h50, 1'b0);
        wait_done("exact_len");
        check("trunc_count_exact", trunc_cnt, 1);

        // Frame error flag only on the final beat
        push_frame(3, 8'h60, 1'b1, 1'b0);
        send_frame(0, 3, 8'h60, 1'b1);
        wait_done("tuser");

        // Reset in the middle of a 6-beat frame
        chk_en = 1'b0;
        acc_n = 0;
        tc = 0;
        drive(0, 1'b1, 8'h70, 1'b0, 1'b0);
        while (acc_n < 3 && tc < BOUND) begin
            @(negedge clk);
            a = s0_trdy;
            @(posedge clk);
            #1;
            tc++;
            if (a) begin
                acc_n++;
                drive(0, 1'b1, DW'(8'h70 + acc_n), (acc_n == 5), 1'b0);
            end
        end
        check("midframe_setup", acc_n, 3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midframe_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("post_reset_quiet", {29'd0, m_tvalid, grant}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk_en = 1'b1;
        push_frame(2, 8'hE0, 1'b0, 1'b0);
        push_frame(2, 8'hF0, 1'b0, 1'b0);
        fork
            send_frame(0, 2, 8'hE0, 1'b0);
            send_frame(1, 2, 8'hF0, 1'b0);
        join
        wait_done("post_reset");
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
